// File: rtl/sensor_cycle_pkg.sv
// Shared definitions for the sensor power/measure/sleep sequencer.
package sensor_cycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_SLEEP   = 2'd3
    } state_t;

endpackage

// File: rtl/sensor_cycle_ctrl_counter.sv
// Loadable up/down counter; Direction_i=1 counts down. Preset wins over counting.
module Counter #(
    parameter int Width = 16
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             ResetSig_i,
    input  logic             Preset_i,
    input  logic [Width-1:0] PresetVal_i,
    input  logic             Enable_i,
    input  logic             Direction_i,
    output logic [Width-1:0] D_o,
    output logic             Overflow_o,
    output logic             Zero_o
);

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            D_o <= '0;
        end else if (ResetSig_i) begin
            D_o <= '0;
        end else if (Preset_i) begin
            D_o <= PresetVal_i;
        end else if (Enable_i) begin
            if (Direction_i) D_o <= D_o - 1'b1;
            else             D_o <= D_o + 1'b1;
        end
    end

    assign Zero_o     = (D_o == '0);
    // Flags the wrap that the next counting step would cause.
    assign Overflow_o = Enable_i && !Preset_i && !ResetSig_i &&
                        (Direction_i ? (D_o == '0) : (&D_o));

endmodule

// File: rtl/sensor_cycle_ctrl.sv
// Duty-cycles a sensor: power-up settle, measure with timeout, then sleep.
module sensor_cycle_ctrl
    import sensor_cycle_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Enable_i,
    input  logic [Width-1:0] PeriodVal_i,
    input  logic [Width-1:0] SettleVal_i,
    input  logic [Width-1:0] TimeoutVal_i,
    input  logic             SensorDone_i,
    output logic             SensorPower_o,
    output logic             SensorStart_o,
    output logic             CpuIntr_o,
    output logic             Timeout_o,
    output logic             Busy_o,
    output state_t           DbgState_o
);

    state_t           state_q, state_d;
    logic             load_q;
    logic             done_q, done_d;
    logic             power_q;
    logic             expired;
    logic             cnt_preset, cnt_enable, cnt_zero;
    logic [Width-1:0] preset_val;
    logic [Width-1:0] cnt_value_unused;
    logic             cnt_overflow_unused;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            power_q <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= (state_d != state_q) && (state_d != ST_IDLE);
            done_q  <= done_d;
            power_q <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        preset_val = '0;
        // Zero_o still shows the previous load during a load cycle.
        expired    = !load_q && cnt_zero;
        if (!Enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_SETTLE;
                ST_SETTLE:  if (expired) state_d = ST_MEASURE;
                ST_MEASURE: begin
                    if (SensorDone_i) begin
                        state_d = ST_SLEEP;
                        done_d  = 1'b1;
                    end else if (expired) begin
                        state_d = ST_SLEEP;
                        done_d  = 1'b0;
                    end
                end
                ST_SLEEP:   if (expired) state_d = ST_SETTLE;
                default:    state_d = ST_IDLE;
            endcase
        end
        case (state_q)
            ST_SETTLE:  preset_val = SettleVal_i;
            ST_MEASURE: preset_val = TimeoutVal_i;
            ST_SLEEP:   preset_val = PeriodVal_i;
            default:    preset_val = '0;
        endcase
        cnt_preset = Enable_i && load_q;
        cnt_enable = Enable_i && !load_q && (state_q != ST_IDLE);
    end

    Counter #(
        .Width(Width)
    ) u_counter (
        .Clk_i      (Clk_i),
        .Reset_n_i  (Reset_n_i),
        .ResetSig_i (1'b0),
        .Preset_i   (cnt_preset),
        .PresetVal_i(preset_val),
        .Enable_i   (cnt_enable),
        .Direction_i(1'b1),
        .D_o        (cnt_value_unused),
        .Overflow_o (cnt_overflow_unused),
        .Zero_o     (cnt_zero)
    );

    assign SensorPower_o = power_q;
    assign SensorStart_o = (state_q == ST_MEASURE) && load_q;
    assign CpuIntr_o     = (state_q == ST_SLEEP) && load_q && done_q;
    assign Timeout_o     = (state_q == ST_SLEEP) && load_q && !done_q;
    assign Busy_o        = (state_q != ST_IDLE);
    assign DbgState_o    = state_q;

endmodule

// File: tb/tb_sensor_cycle_ctrl.sv
// Directed bench: stimulus queues expected events, a negedge monitor compares them.
module tb_sensor_cycle_ctrl;
    import sensor_cycle_pkg::*;

    localparam int W = 8;
    localparam logic [3:0] K_SEG   = 4'h1;
    localparam logic [3:0] K_START = 4'h2;
    localparam logic [3:0] K_INTR  = 4'h3;
    localparam logic [3:0] K_TMO   = 4'h4;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] period_val, settle_val, timeout_val;
    logic         sensor_done;
    logic         sensor_power, sensor_start, cpu_intr, timeout_p, busy;
    state_t       dbg_state;

    logic [23:0]  exp_q[$];
    int           checks;
    int           failures;

    sensor_cycle_ctrl #(.Width(W)) dut (
        .Clk_i        (clk),
        .Reset_n_i    (rst_n),
        .Enable_i     (enable),
        .PeriodVal_i  (period_val),
        .SettleVal_i  (settle_val),
        .TimeoutVal_i (timeout_val),
        .SensorDone_i (sensor_done),
        .SensorPower_o(sensor_power),
        .SensorStart_o(sensor_start),
        .CpuIntr_o    (cpu_intr),
        .Timeout_o    (timeout_p),
        .Busy_o       (busy),
        .DbgState_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [23:0] seg(input state_t st, input int len);
        logic [15:0] l;
        l = len[15:0];
        return {K_SEG, st, 2'b00, l};
    endfunction

    function automatic logic [23:0] ev(input logic [3:0] kind);
        return {kind, 20'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {27'h0, sensor_power, sensor_start, cpu_intr, timeout_p, busy}, 32'h0);
        check({name, "_state"}, {30'h0, dbg_state}, {30'h0, ST_IDLE});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!sensor_start && k < budget);
        check("wait_start", {31'h0, sensor_start}, 32'h1);
    endtask

    task automatic wait_state(input state_t st, input int budget);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (dbg_state != st && k < budget);
        check("wait_state", {30'h0, dbg_state}, {30'h0, st});
    endtask

    // ---------------- monitor / scoreboard ----------------
    state_t prev_st;
    int     seg_len;

    task automatic observe(input logic [23:0] tok);
        logic [23:0] req;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event: got 0x%06h, expected none (queue empty)", tok);
        end else begin
            req = exp_q.pop_front();
            if (tok !== req) begin
                failures++;
                $display("FAIL event: got 0x%06h, expected 0x%06h", tok, req);
            end
        end
    endtask

    initial begin
        prev_st = ST_IDLE;
        seg_len = 0;
    end

    always @(negedge clk) begin
        if (dbg_state != prev_st) begin
            if (prev_st != ST_IDLE) observe(seg(prev_st, seg_len));
            prev_st = dbg_state;
            seg_len = 1;
        end else begin
            seg_len++;
        end
        if (sensor_start) observe(ev(K_START));
        if (cpu_intr)     observe(ev(K_INTR));
        if (timeout_p)    observe(ev(K_TMO));
        if (cpu_intr && timeout_p) begin
            failures++;
            $display("FAIL intr_tmo_excl: got both 1, expected at most one");
        end
        check("power_decode", {31'h0, sensor_power},
              {31'h0, (dbg_state == ST_SETTLE) || (dbg_state == ST_MEASURE)});
        check("busy_decode", {31'h0, busy}, {31'h0, dbg_state != ST_IDLE});
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; enable = 1'b0; sensor_done = 1'b0;
        period_val = 8'd0; settle_val = 8'd3; timeout_val = 8'd20;
        step(3);
        check_idle("reset");
        rst_n = 1'b1;
        step(2);
        check_idle("idle_no_enable");

        // A: done in 5th Measure cycle, then 2-cycle Sleep (period 0)
        exp_q.push_back(seg(ST_SETTLE, 5));  exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 5)); exp_q.push_back(ev(K_INTR));
        exp_q.push_back(seg(ST_SLEEP, 2));
        enable = 1'b1;
        wait_start(50);
        step(4); sensor_done = 1'b1;
        step(1); sensor_done = 1'b0;

        // B: timeout 5 -> 7-cycle Measure and Timeout pulse; next Sleep 10 -> 12
        timeout_val = 8'd5;
        exp_q.push_back(seg(ST_SETTLE, 5));  exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 7)); exp_q.push_back(ev(K_TMO));
        exp_q.push_back(seg(ST_SLEEP, 12));
        wait_start(50);
        period_val = 8'd10;
        wait_state(ST_SLEEP, 50);

        // C: period changed mid-Sleep; done coincides with Measure expiry
        exp_q.push_back(seg(ST_SETTLE, 5));  exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 7)); exp_q.push_back(ev(K_INTR));
        exp_q.push_back(seg(ST_SLEEP, 3));
        step(3); period_val = 8'd1;
        wait_start(50);
        step(6); sensor_done = 1'b1;
        step(1); sensor_done = 1'b0;

        // D: Enable dropped in 3rd Settle cycle
        exp_q.push_back(seg(ST_SETTLE, 3));
        wait_state(ST_SETTLE, 50);
        step(2); enable = 1'b0;
        step(2);
        check_idle("enable_drop");

        // E: reset pulsed in 3rd Measure cycle, then restart in Settle
        timeout_val = 8'd20;
        exp_q.push_back(seg(ST_SETTLE, 5));  exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 2));
        enable = 1'b1;
        wait_start(50);
        step(2); rst_n = 1'b0;
        #1;
        check_idle("reset_async");
        step(3);
        check_idle("reset_held");
        exp_q.push_back(seg(ST_SETTLE, 5));  exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 1));
        rst_n = 1'b1;
        wait_start(50);
        enable = 1'b0;
        step(2);
        check_idle("restart_drop");

        // F: maximum reload value lasts 2^W+1 cycles without wrapping
        settle_val = 8'd255;
        exp_q.push_back(seg(ST_SETTLE, 257)); exp_q.push_back(ev(K_START));
        exp_q.push_back(seg(ST_MEASURE, 1));
        enable = 1'b1;
        wait_start(400);
        enable = 1'b0;
        step(5);
        check_idle("final_idle");
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
